// File: rtl/alu_issue_ctrl.sv
// Issue/decode front end for the 64-bit LEGv8 ALU: decodes one instruction, drives the ALU from registers, returns a tagged result.
// Latency: supported op accepted at edge N gives res_valid after edge N+1; unsupported op gives an error response after edge N.
// Backpressure: in_ready is high only in IDLE; while res_ready is low the response is held with all result outputs stable.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready/instr/rn_data/rm_data request side;
//        alu_a/alu_b/alu_select out to the ALU, alu_out back (combinational);
//        res_valid/res_ready/res_data/res_rd/res_err/res_zero/res_neg response side.
// Optional feature macro: ALU_ISSUE_FLAGS_EN (registered zero/negative flags; tied 0 when undefined).
module alu_issue_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rn_data,
  input  logic [WIDTH-1:0] rm_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_select,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [4:0]       res_rd,
  output logic             res_err,
  output logic             res_zero,
  output logic             res_neg
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_ORR  = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_PASS = 4'b0111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             dec_ok;
  logic [3:0]       dec_sel;
  logic [WIDTH-1:0] dec_b;
  logic             accept;

  // Rn arrives already read as rn_data, so its field in the word is not needed here.
  logic unused_rn_field;
  assign unused_rn_field = ^instr[9:5];

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign res_valid = (state == RESP);

  // Decode: 11-bit opcodes first, then 10-bit immediates, then 8-bit CB format.
  always_comb begin
    dec_ok  = 1'b0;
    dec_sel = SEL_AND;
    dec_b   = rm_data;
    if (instr[31:21] == OP_ADD) begin
      dec_ok = 1'b1; dec_sel = SEL_ADD;
    end else if (instr[31:21] == OP_SUB) begin
      dec_ok = 1'b1; dec_sel = SEL_SUB;
    end else if (instr[31:21] == OP_AND) begin
      dec_ok = 1'b1; dec_sel = SEL_AND;
    end else if (instr[31:21] == OP_ORR) begin
      dec_ok = 1'b1; dec_sel = SEL_ORR;
    end else if ((instr[31:21] == OP_LDUR) || (instr[31:21] == OP_STUR)) begin
      // D-format address offset is a signed 9-bit displacement.
      dec_ok  = 1'b1;
      dec_sel = SEL_ADD;
      dec_b   = {{(WIDTH-9){instr[20]}}, instr[20:12]};
    end else if ((instr[31:22] == OP_ADDI) || (instr[31:22] == OP_SUBI)) begin
      dec_ok  = 1'b1;
      dec_sel = (instr[31:22] == OP_ADDI) ? SEL_ADD : SEL_SUB;
      dec_b   = {{(WIDTH-12){1'b0}}, instr[21:10]};
    end else if (instr[31:24] == OP_CBZ) begin
      // ALU passes Rt through so the branch unit can test it for zero.
      dec_ok  = 1'b1;
      dec_sel = SEL_PASS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = dec_ok ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operands only load on a supported accept, so they hold the last
  // issued values across idle periods and error responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= SEL_AND;
      res_data   <= '0;
      res_rd     <= '0;
      res_err    <= 1'b0;
    end else if (accept) begin
      res_rd <= instr[4:0];
      if (dec_ok) begin
        alu_a      <= rn_data;
        alu_b      <= dec_b;
        alu_select <= dec_sel;
      end else begin
        res_data <= '0;
        res_err  <= 1'b1;
      end
    end else if (state == EXEC) begin
      res_data <= alu_out;
      res_err  <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic zero_q, neg_q;

  // Flags follow the captured result; an error response forces both low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (accept && !dec_ok) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state == EXEC) begin
      zero_q <= (alu_out == '0);
      neg_q  <= alu_out[WIDTH-1];
    end
  end

  assign res_zero = zero_q;
  assign res_neg  = neg_q;
`else
  assign res_zero = 1'b0;
  assign res_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [63:0] rn_data, rm_data;
  logic [63:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_select;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic [4:0]  res_rd;
  logic        res_err, res_zero, res_neg;

  int n_pass  = 0;
  int n_total = 0;

`ifdef ALU_ISSUE_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  alu_issue_ctrl #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rn_data(rn_data), .rm_data(rm_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_err(res_err), .res_zero(res_zero), .res_neg(res_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External LEGv8 ALU stand-in.
  always_comb begin
    case (alu_select)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = alu_b;
      default: alu_out = 64'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Presents one instruction and returns #1 after the accepting edge.
  task automatic send(input logic [31:0] i, input logic [63:0] rn, input logic [63:0] rm);
    int k = 0;
    while (!in_ready && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) chk("ready_timeout", {63'd0, in_ready}, 64'd1);
    instr = i; rn_data = rn; rm_data = rm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Supported op with res_ready held high: EXEC, RESP, then back to IDLE.
  task automatic run_op(input string nm, input logic [31:0] i, input logic [63:0] rn,
                        input logic [63:0] rm, input logic [3:0] e_sel, input logic [63:0] e_b,
                        input logic [63:0] e_data, input logic [4:0] e_rd,
                        input logic e_zero, input logic e_neg);
    send(i, rn, rm);
    chk({nm, "_alu_a"},   alu_a, rn);
    chk({nm, "_alu_b"},   alu_b, e_b);
    chk({nm, "_sel"},     {60'd0, alu_select}, {60'd0, e_sel});
    chk({nm, "_exec_vld"},{63'd0, res_valid}, 64'd0);
    chk({nm, "_exec_rdy"},{63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk({nm, "_vld"},  {63'd0, res_valid}, 64'd1);
    chk({nm, "_data"}, res_data, e_data);
    chk({nm, "_rd"},   {59'd0, res_rd}, {59'd0, e_rd});
    chk({nm, "_err"},  {63'd0, res_err}, 64'd0);
    chk({nm, "_zero"}, {63'd0, res_zero}, {63'd0, e_zero});
    chk({nm, "_neg"},  {63'd0, res_neg}, {63'd0, e_neg});
    @(posedge clk); #1;
    chk({nm, "_idle_rdy"}, {63'd0, in_ready}, 64'd1);
    chk({nm, "_idle_vld"}, {63'd0, res_valid}, 64'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rdy"},  {63'd0, in_ready}, 64'd1);
    chk({nm, "_a"},    alu_a, 64'd0);
    chk({nm, "_b"},    alu_b, 64'd0);
    chk({nm, "_sel"},  {60'd0, alu_select}, 64'd0);
    chk({nm, "_vld"},  {63'd0, res_valid}, 64'd0);
    chk({nm, "_data"}, res_data, 64'd0);
    chk({nm, "_rd"},   {59'd0, res_rd}, 64'd0);
    chk({nm, "_err"},  {63'd0, res_err}, 64'd0);
    chk({nm, "_zero"}, {63'd0, res_zero}, 64'd0);
    chk({nm, "_neg"},  {63'd0, res_neg}, 64'd0);
  endtask

  localparam logic [31:0] I_ADD  = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3};
  localparam logic [31:0] I_SUBI = {10'b1101000100, 12'd5, 5'd1, 5'd4};
  localparam logic [31:0] I_CBZ  = {8'b10110100, 19'd0, 5'd9};
  localparam logic [31:0] I_AND  = {11'b10001010000, 5'd2, 6'd0, 5'd1, 5'd10};
  localparam logic [31:0] I_LDUR = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd5};
  localparam logic [31:0] I_ORR  = {11'b10101010000, 5'd2, 6'd0, 5'd1, 5'd6};
  localparam logic [31:0] I_SUB  = {11'b11001011000, 5'd2, 6'd0, 5'd1, 5'd7};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rn_data = '0; rm_data = '0; res_ready = 1'b1;
    #2;
    chk_reset_vals("rst");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add",  I_ADD,  64'd5, 64'd7, 4'b0010, 64'd7, 64'd12, 5'd3, 1'b0, 1'b0);
    run_op("subi", I_SUBI, 64'd3, 64'd99, 4'b0110, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 5'd4, 1'b0, FL);
    run_op("cbz",  I_CBZ,  64'h1234, 64'd0, 4'b0111, 64'd0, 64'd0, 5'd9, FL, 1'b0);
    run_op("and",  I_AND,  64'hFF00FF, 64'h0F0F0F, 4'b0000, 64'h0F0F0F, 64'h0F000F, 5'd10, 1'b0, 1'b0);
    run_op("ldur", I_LDUR, 64'h100, 64'd77, 4'b0010, 64'hFFFF_FFFF_FFFF_FFF8, 64'hF8, 5'd5, 1'b0, 1'b0);

    // Unsupported word: error response right after the accepting edge.
    send(32'h0000_0000, 64'h55, 64'h66);
    chk("bad_vld",  {63'd0, res_valid}, 64'd1);
    chk("bad_err",  {63'd0, res_err}, 64'd1);
    chk("bad_data", res_data, 64'd0);
    chk("bad_rd",   {59'd0, res_rd}, 64'd0);
    chk("bad_sel",  {60'd0, alu_select}, 64'd2);
    chk("bad_b",    alu_b, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("bad_zero", {63'd0, res_zero}, 64'd0);
    @(posedge clk); #1;
    chk("bad_idle", {63'd0, in_ready}, 64'd1);

    // Backpressure with in_valid pulsing during RESP.
    res_ready = 1'b0;
    send(I_ORR, 64'hF0, 64'h0F);
    chk("orr_sel", {60'd0, alu_select}, 64'd1);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_vld",  {63'd0, res_valid}, 64'd1);
      chk("bp_data", res_data, 64'hFF);
      chk("bp_rd",   {59'd0, res_rd}, 64'd6);
      chk("bp_rdy",  {63'd0, in_ready}, 64'd0);
      chk("bp_sel",  {60'd0, alu_select}, 64'd1);
      in_valid = c[0]; instr = I_ADD; rn_data = 64'd1; rm_data = 64'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_a_held", alu_a, 64'hF0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_rdy", {63'd0, in_ready}, 64'd1);
    chk("bp_release_vld", {63'd0, res_valid}, 64'd0);

    // Asynchronous reset in the middle of EXEC.
    send(I_SUB, 64'd50, 64'd8);
    chk("sub_exec", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("add2", I_ADD, 64'd100, 64'd23, 4'b0010, 64'd23, 64'd123, 5'd3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
